ecc_hamming_faulty_mem: RTL and testbench

- 16-entry x 8-bit memory that stores every word as a Hamming(12,8) single-error-correcting codeword.
- On read, the stored codeword can have one bit flipped by a test-controlled fault injector; the decoder corrects it and flags the correction.
- Used as a self-contained ECC/fault-injection demonstrator and as the reference SEC memory for the protection-code study.

---
 rtl/ecc_hamming_pkg.sv | 40 ++++
 rtl/hamming_sec_decoder.sv | 28 ++
 rtl/ecc_hamming_faulty_mem.sv | 62 ++++++
 tb/tb_ecc_hamming_faulty_mem.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ecc_hamming_pkg.sv
// Shared constants and pure Hamming(12,8) helpers for the ECC demonstrator memory.
// Codeword bit i holds Hamming position i+1; parity at 1,2,4,8, data at the rest.
package ecc_hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam int unsigned PARITY_POS [4]      = '{1, 2, 4, 8};
  localparam int unsigned DATA_POS   [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic              p;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[4'(DATA_POS[i] - 1)] = data[i];
    end
    // Each parity position only covers itself among parity positions, so it is still 0 here.
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= CODE_W; pos++) begin
        if ((pos & (1 << k)) != 0) p = p ^ cw[4'(pos - 1)];
      end
      cw[4'(PARITY_POS[k] - 1)] = p;
    end
    return cw;
  endfunction

  function automatic logic [3:0] hamming_syndrome(input logic [CODE_W-1:0] cw);
    logic [3:0] s;
    s = '0;
    for (int pos = 1; pos <= CODE_W; pos++) begin
      if (cw[4'(pos - 1)]) s = s ^ 4'(pos);
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_sec_decoder.sv
// Combinational single-error-correcting Hamming(12,8) decoder.
module hamming_sec_decoder
  import ecc_hamming_pkg::*;
(
  input  logic [CODE_W-1:0] codeword,
  output logic [DATA_W-1:0] data,
  output logic              corrected
);

  logic [3:0]        syndrome;
  logic [CODE_W-1:0] fixed;

  // Syndromes 13..15 point outside the codeword, so the word is passed through unflagged.
  always_comb begin
    syndrome  = hamming_syndrome(codeword);
    fixed     = codeword;
    corrected = 1'b0;
    if (syndrome != 4'd0 && syndrome <= 4'(CODE_W)) begin
      fixed     = codeword ^ ({{(CODE_W-1){1'b0}}, 1'b1} << (syndrome - 4'd1));
      corrected = 1'b1;
    end
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = fixed[4'(DATA_POS[i] - 1)];
    end
  end

endmodule

// File: rtl/ecc_hamming_faulty_mem.sv
// 16x8 memory stored as Hamming(12,8) codewords with a registered, corrected read.
// Define FAULT_INJECT_EN to enable the single-bit read-path fault injector.
module ecc_hamming_faulty_mem
  import ecc_hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_data,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic              wr_en,
  input  logic [3:0]        fault_addr,
  input  logic              fault_enable,
  output logic [DATA_W-1:0] output_data,
  output logic              single_bit_error_corrected
);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [CODE_W-1:0] fault_mask;
  logic [CODE_W-1:0] read_word;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corrected;

`ifdef FAULT_INJECT_EN
  // The fault only touches the read path; stored words are never altered.
  always_comb begin
    fault_mask = '0;
    if (fault_enable && fault_addr <= 4'd11) fault_mask = CODE_W'(1) << fault_addr;
  end
`else
  logic unused_fault;
  assign unused_fault = ^{fault_addr, fault_enable};
  assign fault_mask   = '0;
`endif

  assign read_word = mem[input_addr] ^ fault_mask;

  hamming_sec_decoder u_decoder (
    .codeword  (read_word),
    .data      (dec_data),
    .corrected (dec_corrected)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[input_addr] <= hamming_encode(input_data);
    end
  end

  // Sampling the old word in the same edge as a write gives read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_data                <= '0;
      single_bit_error_corrected <= 1'b0;
    end else begin
      output_data                <= dec_data;
      single_bit_error_corrected <= dec_corrected;
    end
  end

endmodule

// File: tb/tb_ecc_hamming_faulty_mem.sv
// Self-checking bench for ecc_hamming_faulty_mem: behavioural data-level model plus literal pins.
module tb_ecc_hamming_faulty_mem;

  logic       clk;
  logic       rst;
  logic [7:0] input_data;
  logic [3:0] input_addr;
  logic       wr_en;
  logic [3:0] fault_addr;
  logic       fault_enable;
  logic [7:0] output_data;
  logic       single_bit_error_corrected;

  int n_compared;
  int n_mismatched;
  bit check_en;

  logic [7:0] model_mem [16];
  logic [7:0] exp_data;
  logic       exp_flag;
  logic [7:0] pat [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h1E, 8'hB4};

  ecc_hamming_faulty_mem dut (
    .clk                        (clk),
    .rst                        (rst),
    .input_data                 (input_data),
    .input_addr                 (input_addr),
    .wr_en                      (wr_en),
    .fault_addr                 (fault_addr),
    .fault_enable               (fault_enable),
    .output_data                (output_data),
    .single_bit_error_corrected (single_bit_error_corrected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A correction is reported exactly when the injector really flips a bit of a valid word.
  function automatic bit fault_active(input logic en, input logic [3:0] fa);
`ifdef FAULT_INJECT_EN
    return en && (fa < 4'd12);
`else
    return 1'b0;
`endif
  endfunction

  // Reference encoder from the position rules: data fills non-power-of-two positions in order.
  function automatic logic [11:0] model_encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        p;
    int          j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 12; pos++) begin
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ cw[pos-1];
      end
      cw[(1 << k) - 1] = p;
    end
    return cw;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the output is simply the stored data of the sampled address, before any same-edge write.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) model_mem[i] <= 8'h00;
      exp_data <= 8'h00;
      exp_flag <= 1'b0;
    end else begin
      exp_data <= model_mem[input_addr];
      exp_flag <= fault_active(fault_enable, fault_addr);
      if (wr_en) model_mem[input_addr] <= input_data;
    end
  end

  always @(negedge clk) begin
    if (check_en && rst) begin
      checkOutput("model_data", {24'h0, output_data}, {24'h0, exp_data});
      checkOutput("model_flag", {31'h0, single_bit_error_corrected}, {31'h0, exp_flag});
    end
  end

  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                               input logic fen, input logic [3:0] faddr);
    @(negedge clk);
    wr_en        = wr;
    input_addr   = addr;
    input_data   = data;
    fault_enable = fen;
    fault_addr   = faddr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    check_en     = 1'b0;
    rst          = 1'b0;
    wr_en        = 1'b0;
    input_data   = 8'h00;
    input_addr   = 4'h0;
    fault_addr   = 4'h0;
    fault_enable = 1'b0;
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    check_en = 1'b1;

    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    checkOutput("reset_read_data", {24'h0, output_data}, 32'h00);
    checkOutput("reset_read_flag", {31'h0, single_bit_error_corrected}, 32'h0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), pat[i], 1'b0, 4'd0);

    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    checkOutput("read_a5", {24'h0, output_data}, 32'hA5);
    checkOutput("encode_a5", {20'h0, dut.mem[0]}, 32'hA27);
    for (int i = 1; i < 8; i++) applyStimulus(1'b0, 4'(i), 8'h00, 1'b0, 4'd0);

    for (int a = 0; a < 8; a++)
      for (int f = 0; f < 12; f++) applyStimulus(1'b0, 4'(a), 8'h00, 1'b1, 4'(f));

    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    checkOutput("flag_clears", {31'h0, single_bit_error_corrected}, 32'h0);
    for (int i = 1; i < 8; i++) applyStimulus(1'b0, 4'(i), 8'h00, 1'b0, 4'd0);

    applyStimulus(1'b0, 4'd2, 8'h00, 1'b1, 4'd13);
    checkOutput("fault13_data", {24'h0, output_data}, 32'hFF);
    checkOutput("fault13_flag", {31'h0, single_bit_error_corrected}, 32'h0);

    applyStimulus(1'b1, 4'd3, 8'h77, 1'b0, 4'd0);
    checkOutput("rbw_old", {24'h0, output_data}, 32'h00);
    applyStimulus(1'b0, 4'd3, 8'h00, 1'b0, 4'd0);
    checkOutput("rbw_new", {24'h0, output_data}, 32'h77);

    applyStimulus(1'b0, 4'd3, 8'h00, 1'b0, 4'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_data", {24'h0, output_data}, 32'h00);
    checkOutput("async_reset_flag", {31'h0, single_bit_error_corrected}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 4'(i), 8'h00, 1'b0, 4'd0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 8'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

    for (int a = 0; a < 16; a++)
      checkOutput("stored_codeword", {20'h0, dut.mem[a]}, {20'h0, model_encode(model_mem[a])});

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
